// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a synchronous FIFO read port (r_en/empty, 1-cycle data) into a valid/ready stream.
// Latency: fifo_empty falling at cycle N gives m_valid at N+2; 1 word/cycle sustained under continuous m_ready.
// Backpressure: at most 2 words buffered or in flight; reads stop until a pop frees a slot. Option: FIFO_RD_COUNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  // Buffer occupancy doubles as the control state; encodings equal the word count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t                  occ, occ_nxt;
  logic [DATA_WIDTH-1:0] head, head_nxt;
  logic [DATA_WIDTH-1:0] spare, spare_nxt;
  logic                  pending;
  logic                  pop;
  logic                  push;
  logic [1:0]            occ_cnt;
  logic [2:0]            committed;

  assign occ_cnt = occ;
  assign m_valid = (occ != S_EMPTY);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;
  assign push    = pending;

  // Words that will still be held after this edge: buffered plus in flight, minus the one leaving.
  // pop implies occ >= 1, so the subtraction never underflows.
  assign committed = {1'b0, occ_cnt} + {2'b00, pending} - {2'b00, pop};

  // Issue a read only when a slot is guaranteed for the returning word; reset and flush block issue.
  assign fifo_r_en = rst & ~flush & ~fifo_empty & (committed < 3'd2);

  // State and data registers for the two-entry skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ   <= S_EMPTY;
      head  <= '0;
      spare <= '0;
    end else begin
      occ   <= occ_nxt;
      head  <= head_nxt;
      spare <= spare_nxt;
    end
  end

  // A read accepted by the FIFO this cycle returns data on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= fifo_r_en & ~fifo_empty;
    end
  end

  // Next occupancy and entry placement for every push/pop combination; flush discards everything
  // except the head value, which stays visible on m_data.
  always_comb begin
    occ_nxt   = occ;
    head_nxt  = head;
    spare_nxt = spare;
    if (flush) begin
      occ_nxt = S_EMPTY;
    end else begin
      unique case (occ)
        S_EMPTY: begin
          if (push) begin
            head_nxt = fifo_data;
            occ_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_nxt = fifo_data;
          end else if (push) begin
            spare_nxt = fifo_data;
            occ_nxt   = S_TWO;
          end else if (pop) begin
            occ_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          // The credit rule keeps push out of this state; accepting it here still preserves order.
          if (pop) begin
            head_nxt = spare;
            if (push) begin
              spare_nxt = fifo_data;
            end else begin
              occ_nxt = S_ONE;
            end
          end
        end
        default: begin
          occ_nxt = S_EMPTY;
        end
      endcase
    end
  end

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  // Count completed pops, wrapping naturally; a pop in the flush cycle is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign rd_count = cnt;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO feeding the DUT, scoreboard of expected stream words.
// Directed steps: latency, backpressure, ready toggling, flush, async reset, counter wrap.
// Honours FIFO_RD_COUNT_EN for the expected rd_count values.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] rd_count;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int errors;
  int checks;
  int pops;
  int ren_pulses;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef FIFO_RD_COUNT_EN
    return 4'(n);
`else
    return 4'(n & 0);
`endif
  endfunction

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: check stream output and read protocol, then model the FIFO's registered read.
  task automatic tick();
    logic rd;
    #1;
    if (fifo_r_en === 1'b1) chk("ren_while_empty", {31'd0, fifo_empty}, 32'd0);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("sb_extra_pop", {31'd0, m_valid}, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, m_data}, {24'd0, e});
      end
    end
    rd = (fifo_r_en === 1'b1) && !fifo_empty;
    if (rd) ren_pulses++;
    @(posedge clk);
    #1;
    if (rd) begin
      fifo_data  = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int maxc);
    for (int i = 0; i < maxc && (exp_q.size() != 0 || m_valid === 1'b1); i++) tick();
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int p0;
    errors     = 0;
    checks     = 0;
    pops       = 0;
    ren_pulses = 0;
    rst        = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
    chk("rst_rd_count", {28'd0, rd_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: latency N / N+2 and back-to-back delivery
    m_ready = 1'b1;
    push_words(8'hA1, 3);
    #1;
    chk("t1_ren_at_N", {31'd0, fifo_r_en}, 32'd1);
    chk("t1_valid_at_N", {31'd0, m_valid}, 32'd0);
    tick();
    chk("t1_valid_at_N1", {31'd0, m_valid}, 32'd0);
    tick();
    chk("t1_valid_at_N2", {31'd0, m_valid}, 32'd1);
    chk("t1_data_at_N2", {24'd0, m_data}, 32'hA1);
    p0 = pops;
    tick(); tick(); tick();
    chk("t1_three_in_a_row", pops - p0, 32'd3);
    drain("t1_drain", 10);
    chk("t1_valid_drops", {31'd0, m_valid}, 32'd0);
    chk("t1_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt(3)});

    // 2: backpressure holds two words, then full rate
    m_ready = 1'b0;
    ren_pulses = 0;
    push_words(8'hB0, 5);
    repeat (8) tick();
    chk("t2_ren_pulses", ren_pulses, 32'd2);
    chk("t2_valid_held", {31'd0, m_valid}, 32'd1);
    chk("t2_data_held", {24'd0, m_data}, 32'hB0);
    chk("t2_ren_blocked", {31'd0, fifo_r_en}, 32'd0);
    m_ready = 1'b1;
    p0 = pops;
    repeat (5) tick();
    chk("t2_no_gaps", pops - p0, 32'd5);
    drain("t2_drain", 10);

    // 3: ready toggling 1,0,1,0
    push_words(8'hC0, 6);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    tick(); tick();
    chk("t3_all_delivered", exp_q.size(), 32'd0);
    chk("t3_valid_drops", {31'd0, m_valid}, 32'd0);

    // 4: flush with one buffered and one in-flight word after a pop
    m_ready = 1'b0;
    push_words(8'hD0, 6);
    repeat (4) tick();
    chk("t4_occ2_data", {24'd0, m_data}, 32'hD0);
    chk("t4_occ2_ren", {31'd0, fifo_r_en}, 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush   = 1'b1;
    #1;
    chk("t4_ren_in_flush", {31'd0, fifo_r_en}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_valid_after_flush", {31'd0, m_valid}, 32'd0);
    chk("t4_data_holds", {24'd0, m_data}, 32'hD1);
    chk("t4_count_after_flush", {28'd0, rd_count}, 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    drain("t4_drain", 20);
    chk("t4_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt(3)});

    // 5: asynchronous reset mid-stream
    push_words(8'hE0, 6);
    repeat (3) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("t5_valid_in_rst", {31'd0, m_valid}, 32'd0);
    chk("t5_ren_in_rst", {31'd0, fifo_r_en}, 32'd0);
    chk("t5_count_in_rst", {28'd0, rd_count}, 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick(); tick();
    rst = 1'b1;
    drain("t5_drain", 20);
    chk("t5_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt(3)});

    // 6: counter wraps at 16
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_words(8'h40, 17);
    drain("t6_drain", 60);
    chk("t6_rd_count_wrap", {28'd0, rd_count}, {28'd0, exp_cnt(17)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
